// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width,
// FSM state encoding, result-flag bundle and the bit-counter sizing helper.
package serial_subtractor_8bit_pkg;

    localparam int WIDTH_DEFAULT = 8;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Status flags published alongside the difference
    typedef struct packed {
        logic bo;   // unsigned borrow-out
        logic v;    // signed overflow
    } flags_t;

    // Width of a counter that must hold 0 .. w-1 (at least one bit)
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w);
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_8bit_if.sv
// Request/result bundle of the serial subtractor.
//   start, A, B, Bi : request side (driven by the master)
//   D, Bo, V        : result and flags, held between operations
//   busy, done      : progress status (done is a one-cycle pulse)
interface serial_subtractor_8bit_if
    import serial_subtractor_8bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bi;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             V;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Bi,
        input  D, Bo, V, busy, done
    );

    modport slave (
        input  start, A, B, Bi,
        output D, Bo, V, busy, done
    );
endinterface

// File: rtl/serial_subtractor_8bit_full_subtractor.sv
// One-bit full subtractor cell: computes a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bout   : difference bit, borrow-out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when a == b and a borrow is pending
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: D = A - B - Bi (mod 2^WIDTH), one bit per cycle, LSB
// first, through a single full_subtractor cell.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : request (start, A, B, Bi) and result (D, Bo, V, busy, done)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; operands captured on the accepting edge
// ST_SHIFT | WIDTH cycles, one difference bit per cycle (busy=1)
// ST_DONE  | one-cycle done pulse, results valid; back to IDLE next edge
module serial_subtractor_8bit
    import serial_subtractor_8bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_subtractor_8bit_if.slave bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    flags_t           flags_q, flags_d;

    logic             cell_d;
    logic             cell_bout;

    // Operand shift registers move right, so bit 0 is always the current bit
    full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        d_out_d  = d_out_q;
        flags_d  = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.A;
                    b_sh_d   = bus.B;
                    borrow_d = bus.Bi;
                    res_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = cell_bout;
                res_d    = {cell_d, res_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    state_d    = ST_DONE;
                    // Last bit: shift registers still hold the operand MSBs,
                    // and cell_d is the result MSB.
                    d_out_d    = {cell_d, res_q[WIDTH-1:1]};
                    flags_d.bo = cell_bout;
                    flags_d.v  = (a_sh_q[0] ^ b_sh_q[0]) & (cell_d ^ a_sh_q[0]);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            d_out_q  <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            d_out_q  <= d_out_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.D    = d_out_q;
    assign bus.Bo   = flags_q.bo;
    assign bus.V    = flags_q.v;
    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_DONE);

endmodule
